mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  MEM-stage data-memory access controller. Sits between the EX/MEM pipeline register and the MEM/WB register.
//  Turns MemRead/MemWrite from EX/MEM into a req/ack transaction on a multi-cycle data memory.
//  Stalls the pipeline until the access finishes, then presents load data for MEM/WB to latch.
//  Flags misaligned word accesses and memory timeouts.
// PARAMETERS
//  DATA_W   32  data and address width
//  TIMEOUT  16  max BUSY cycles without ack before abort (>=2)
// PORTS
//  clk_i          in   1       clock, rising edge
//  rst_i          in   1       synchronous reset, active-high
//  MemRead_i      in   1       load in MEM stage (from EX/MEM)
//  MemWrite_i     in   1       store in MEM stage (from EX/MEM)
//  Addr_i         in   DATA_W  byte address (ALU result)
//  WriteData_i    in   DATA_W  store data
//  mem_req_o      out  1       request to data memory (registered)
//  mem_we_o       out  1       1=write, 0=read (registered)
//  mem_addr_o     out  DATA_W  captured address (registered)
//  mem_wdata_o    out  DATA_W  captured store data (registered)
//  mem_ack_i      in   1       memory completion, 1-cycle pulse
//  mem_rdata_i    in   DATA_W  read data, valid with mem_ack_i
//  ReadData_o     out  DATA_W  load data to MEM/WB (registered)
//  stall_o        out  1       freeze PC/IF/ID/ID-EX/EX-MEM; MEM/WB takes a bubble (combinational)
//  misaligned_o   out  1       valid in DONE only: access had Addr_i[1:0]!=0
//  timeout_o      out  1       valid in DONE only: access aborted on timeout
// BEHAVIOUR
//  Reset (sync): state=IDLE; mem_req_o=0; mem_we_o=0; mem_addr_o=0; mem_wdata_o=0.
//   Also ReadData_o=0, misaligned_o=0, timeout_o=0, wait counter=0.
//  Reset mid-transaction drops req immediately. A later stray ack is ignored.
//  access = MemRead_i|MemWrite_i. If both are set, treat as a write.
//  FSM:
//   IDLE: stall_o=access. Without access, stay in IDLE; ReadData_o holds its value.
//     access, Addr_i[1:0]==0: capture addr/wdata/we, mem_req_o<=1, cnt<=0, go to BUSY.
//     access, misaligned: no request; ReadData_o<=0, misaligned_o<=1, go to DONE.
//   BUSY: stall_o=1; mem_req_o is held until the transaction ends.
//     mem_ack_i=1: mem_req_o<=0; on a read, ReadData_o<=mem_rdata_i; go to DONE.
//     no ack, cnt==TIMEOUT-1: mem_req_o<=0, ReadData_o<=0, timeout_o<=1, go to DONE.
//     otherwise cnt<=cnt+1. If ack and the timeout hit the same cycle, ack wins.
//   DONE: stall_o=0. The pipeline advances and MEM/WB latches ReadData_o at this edge.
//     Always go to IDLE and clear misaligned_o/timeout_o.
//     Never re-issue in DONE, even though EX/MEM still holds the same op.
//  A store leaves ReadData_o unchanged.
//  mem_ack_i is ignored in IDLE/DONE and while mem_req_o=0.
//  Latency: ack in the first BUSY cycle gives IDLE,BUSY,DONE = 2 stall cycles; each extra wait adds 1.
//  Back-to-back accesses: DONE->IDLE, then the next op is seen in IDLE, with no gap cycle.
//  cnt width = $clog2(TIMEOUT); the counter never wraps.
// TESTING
//  1 LW 0x100, ack in first BUSY, rdata=0xDEADBEEF -> stall 2 cycles, req 1 cycle, ReadData_o=0xDEADBEEF in DONE.
//  2 SW 0x104, data 0x12345678, ack after 3 waits -> mem_we_o=1, mem_wdata_o=0x12345678, stall 5 cycles, ReadData_o unchanged.
//  3 LW 0x102 -> no req, 1 stall, DONE: misaligned_o=1, ReadData_o=0.
//  4 LW with no ack, TIMEOUT=16 -> req held 16 cycles, DONE: timeout_o=1, ReadData_o=0; ack then on cycle 16 -> normal completion.
//  5 LW then SW back-to-back, each acked immediately -> 2 transactions, no duplicate req in DONE, 4 stall cycles total.
//  6 rst_i pulse in BUSY, ack 1 cycle later -> req=0 next cycle, state IDLE, ack ignored, all outputs 0.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: req/ack bus between the MEM-stage controller and the data memory
interface mem_access_ctrl_if #(parameter int DATA_W = 32);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
  modport slave (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory access controller with stall, misalignment and timeout reporting
module mem_access_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                MemRead_i,
  input  logic                MemWrite_i,
  input  logic [DATA_W-1:0]   Addr_i,
  input  logic [DATA_W-1:0]   WriteData_i,
  mem_access_ctrl_if.master   bus,
  output logic [DATA_W-1:0]   ReadData_o,
  output logic                stall_o,
  output logic                misaligned_o,
  output logic                timeout_o
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic              req_q, req_d, we_q, we_d, mis_q, mis_d, to_q, to_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic access, aligned, ack, expire;
  assign access  = MemRead_i | MemWrite_i;
  assign aligned = Addr_i[1:0] == 2'b00;
  assign ack     = bus.mem_ack & req_q;
  assign expire  = cnt_q == CW'(TIMEOUT - 1);
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign ReadData_o    = rdata_q;
  assign misaligned_o  = mis_q;
  assign timeout_o     = to_q;
  // state and datapath registers, synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end
  // next state: DONE always returns to IDLE so the held EX/MEM op is never re-issued
  always_comb begin
    state_d = state_q == IDLE ? (access ? (aligned ? BUSY : DONE) : IDLE) :
              state_q == BUSY ? ((ack || expire) ? DONE : BUSY) : IDLE;
  end
  // outputs and datapath updates; ack takes priority over an expiring wait counter
  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        stall_o = access;
        if (access && aligned) begin
          req_d   = 1'b1;
          we_d    = MemWrite_i;
          addr_d  = Addr_i;
          wdata_d = WriteData_i;
          cnt_d   = '0;
        end else if (access) begin
          rdata_d = '0;
          mis_d   = 1'b1;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (ack) begin
          req_d   = 1'b0;
          rdata_d = we_q ? rdata_q : bus.mem_rdata;
        end else if (expire) begin
          req_d   = 1'b0;
          rdata_d = '0;
          to_d    = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
      end
      default: begin
        mis_d = 1'b0;
        to_d  = 1'b0;
      end
    endcase
  end
endmodule
